traffic_phase_arbiter: RTL and testbench
========================================

TRAFFIC_PHASE_ARBITER -- requirements
Module: traffic_phase_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning; all are cycle counts in 1..255.
  GREEN_MIN  8   minimum green duration
  GREEN_MAX  32  maximum green duration while competing demand exists
  YELLOW_T   4   yellow duration
  ALLRED_T   2   all-red clearance duration
  WALK_T     10  pedestrian walk duration
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk      in   1  single clock, rising edge
  rst      in   1  synchronous, active-high reset
  veh_req  in   4  level vehicle demand; bit0 N, bit1 S, bit2 E, bit3 W
  ped_btn  in   1  pedestrian button; any high cycle counts as a press
  north    out  3  light state: 100 red, 010 yellow, 001 green
  south    out  3  same encoding as north
  east     out  3  same encoding as north
  west     out  3  same encoding as north
  walk     out  1  pedestrian walk indication
  phase    out  2  index of the approach currently holding, or last holding, green (0 N, 1 S, 2 E, 3 W)
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; all outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have four states: ALL_RED, GREEN, YELLOW and WALK; a single 8-bit down-counter times every state.
REQ-005 In ALL_RED and WALK all four lights SHALL be 100; in GREEN/YELLOW only approach[phase] SHALL be non-red (001/010).
REQ-006 walk SHALL be 1 only in WALK; walk=1 with any light non-red is forbidden.
REQ-007 A press (ped_btn=1) in any cycle outside WALK SHALL set ped_pending; presses during WALK SHALL be ignored.
REQ-008 ALL_RED SHALL last at least ALLRED_T cycles; on expiry, evaluation SHALL use registered ped_pending.
  - If ped_pending=1, the FSM SHALL go to WALK, clear ped_pending and load WALK_T.
  - Otherwise, if any veh_req bit is set, the FSM SHALL go to GREEN for the first set bit in round-robin order starting at phase+1 (mod 4), update phase and load the green timer.
  - Otherwise the FSM SHALL stay in ALL_RED and re-evaluate every cycle.
REQ-009 Competing demand SHALL be ped_pending=1 or any veh_req bit other than bit[phase].
REQ-010 GREEN SHALL last at least GREEN_MIN cycles; it SHALL exit to YELLOW at the first cycle where either condition holds:
  - (a) elapsed >= GREEN_MIN, veh_req[phase]=0 and competing demand exists (gap-out);
  - (b) elapsed >= GREEN_MAX and competing demand exists (max-out).
REQ-011 With no competing demand, GREEN SHALL rest indefinitely, whatever the state of veh_req[phase]; the elapsed count SHALL saturate at 255.
REQ-012 YELLOW SHALL last exactly YELLOW_T cycles, then go to ALL_RED and load ALLRED_T.
REQ-013 WALK SHALL last exactly WALK_T cycles, then go to ALL_RED; phase SHALL be unchanged by WALK.
REQ-014 A press in the same cycle as ALL_RED expiry SHALL only be latched; it is served at the next ALL_RED expiry.
REQ-015 veh_req changes during YELLOW or ALL_RED timing SHALL NOT alter those durations.

Reset
REQ-016 While rst=1 at a clock edge, the block SHALL apply the reset values:
  - state ALL_RED, timer loaded with ALLRED_T;
  - north/south/east/west = 100, walk = 0;
  - phase = 3, so N is first in round-robin order;
  - ped_pending = 0, green elapsed count = 0.
REQ-017 Reset asserted in any state, including mid-GREEN, mid-YELLOW or mid-WALK, SHALL take effect at the next edge with no intermediate yellow.

Verification
REQ-018 The bench SHALL cover the following directed scenarios (default parameters):
  1. Reset, then veh_req=0, ped_btn=0 -> all lights 100, walk=0, phase=3 indefinitely.
  2. veh_req=0001 held from reset release -> north=001 after 2 all-red cycles; remains green for 100+ cycles (no competition).
  3. veh_req=0101 held -> N green 32, yellow 4, all-red 2, E green 32, yellow 4, all-red 2, N green...; phase alternates 0/2.
  4. veh_req=0001 held, ped_btn pulse during N green -> N green 32 cycles, yellow 4, all-red 2, walk=1 for 10, all-red 2, N green again.
  5. N green with veh_req[0] dropped at green cycle 3, veh_req[2]=1 -> N yellow begins after exactly 8 green cycles; E green follows the 2-cycle all-red.
  6. rst pulsed during N yellow -> next cycle all 100, walk=0, phase=3; a ped_btn press latched before the reset is not served.
REQ-019 In every scenario the bench SHALL check every cycle: at most one light non-red; walk=1 only when all four lights are 100; every light output one-hot.

Source files
------------

// File: rtl/traffic_phase_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : traffic_phase_arbiter                                        |
// | Description : Four-approach intersection controller with a pedestrian      |
// |               walk phase. Round-robin selection among vehicle demands,     |
// |               actuated green (gap-out / max-out), fixed yellow, all-red    |
// |               clearance and a walk interval served from a latched button.  |
// | Ports       : clk      - clock, rising edge                                |
// |               rst      - synchronous active-high reset                     |
// |               veh_req  - level vehicle demand, bit0 N / 1 S / 2 E / 3 W    |
// |               ped_btn  - pedestrian button, any high cycle is a press      |
// |               north/south/east/west - light, 100 red/010 yellow/001 green  |
// |               walk     - pedestrian walk indication                        |
// |               phase    - approach holding (or last holding) green          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module traffic_phase_arbiter #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] veh_req,
    input  logic       ped_btn,
    output logic [2:0] north,
    output logic [2:0] south,
    output logic [2:0] east,
    output logic [2:0] west,
    output logic       walk,
    output logic [1:0] phase
);

    localparam logic [7:0] C_GREEN_MIN = 8'(GREEN_MIN);
    localparam logic [7:0] C_GREEN_MAX = 8'(GREEN_MAX);
    localparam logic [7:0] C_YELLOW_T  = 8'(YELLOW_T);
    localparam logic [7:0] C_ALLRED_T  = 8'(ALLRED_T);
    localparam logic [7:0] C_WALK_T    = 8'(WALK_T);

    localparam logic [2:0] C_RED = 3'b100;
    localparam logic [2:0] C_YEL = 3'b010;
    localparam logic [2:0] C_GRN = 3'b001;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_WALK    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] elapsed_q, elapsed_d;
    logic [1:0] phase_q, phase_d;
    logic       ped_pending_q, ped_pending_d;

    logic       w_rr_found;
    logic [1:0] w_rr_idx;
    logic [3:0] w_phase_mask;
    logic       w_compete;
    logic       w_green_exit;

    // Round-robin search: the approach after the current phase has highest
    // priority and the current phase itself is considered last.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = phase_q;
        for (int i = 1; i <= 4; i++) begin
            if (!w_rr_found && veh_req[phase_q + 2'(i)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = phase_q + 2'(i);
            end
        end
    end

    assign w_phase_mask = 4'b0001 << phase_q;
    assign w_compete    = ped_pending_q | (|(veh_req & ~w_phase_mask));
    // elapsed_q is 1 in the first green cycle, so the comparisons below
    // give exactly GREEN_MIN / GREEN_MAX green cycles before yellow.
    assign w_green_exit = w_compete &
                          (((elapsed_q >= C_GREEN_MIN) & ~veh_req[phase_q]) |
                           (elapsed_q >= C_GREEN_MAX));

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        elapsed_d     = elapsed_q;
        phase_d       = phase_q;
        // Presses are latched everywhere except during the walk interval.
        ped_pending_d = ped_pending_q | (ped_btn & (state_q != ST_WALK));

        case (state_q)
            ST_ALL_RED: begin
                if (timer_q > 8'd1) begin
                    timer_d = timer_q - 8'd1;
                end else if (ped_pending_q) begin
                    // A press arriving on this very cycle stays pending and
                    // is served at the following clearance expiry.
                    state_d       = ST_WALK;
                    timer_d       = C_WALK_T;
                    ped_pending_d = ped_btn;
                end else if (w_rr_found) begin
                    state_d   = ST_GREEN;
                    phase_d   = w_rr_idx;
                    elapsed_d = 8'd1;
                end
                // With no demand the timer stays at 1 so every cycle is an
                // evaluation point.
            end
            ST_GREEN: begin
                if (w_green_exit) begin
                    state_d   = ST_YELLOW;
                    timer_d   = C_YELLOW_T;
                    elapsed_d = 8'd0;
                end else if (elapsed_q != 8'hFF) begin
                    elapsed_d = elapsed_q + 8'd1;
                end
            end
            ST_YELLOW: begin
                if (timer_q > 8'd1) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    state_d = ST_ALL_RED;
                    timer_d = C_ALLRED_T;
                end
            end
            ST_WALK: begin
                if (timer_q > 8'd1) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    state_d = ST_ALL_RED;
                    timer_d = C_ALLRED_T;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                timer_d = C_ALLRED_T;
            end
        endcase
    end

    function automatic logic [2:0] f_light(input state_t st, input logic [1:0] ph,
                                           input logic [1:0] me);
        if (ph == me && st == ST_GREEN)  return C_GRN;
        if (ph == me && st == ST_YELLOW) return C_YEL;
        return C_RED;
    endfunction

    // Light outputs are registered from the next-state values so they line
    // up with state_q in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ALL_RED;
            timer_q       <= C_ALLRED_T;
            elapsed_q     <= 8'd0;
            phase_q       <= 2'd3;
            ped_pending_q <= 1'b0;
            north         <= C_RED;
            south         <= C_RED;
            east          <= C_RED;
            west          <= C_RED;
            walk          <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            elapsed_q     <= elapsed_d;
            phase_q       <= phase_d;
            ped_pending_q <= ped_pending_d;
            north         <= f_light(state_d, phase_d, 2'd0);
            south         <= f_light(state_d, phase_d, 2'd1);
            east          <= f_light(state_d, phase_d, 2'd2);
            west          <= f_light(state_d, phase_d, 2'd3);
            walk          <= (state_d == ST_WALK);
        end
    end

    assign phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_traffic_phase_arbiter                                     |
// | Description : Self-checking bench for traffic_phase_arbiter: directed      |
// |               vector table, multi-cycle corner sequences and randomized    |
// |               traffic compared against a behavioural model.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_traffic_phase_arbiter;

    localparam int GREEN_MIN = 8;
    localparam int GREEN_MAX = 32;
    localparam int YELLOW_T  = 4;
    localparam int ALLRED_T  = 2;
    localparam int WALK_T    = 10;

    // Light patterns packed as {north, south, east, west}.
    localparam logic [11:0] L_ALLRED = 12'b100_100_100_100;
    localparam logic [11:0] L_NG     = 12'b001_100_100_100;
    localparam logic [11:0] L_NY     = 12'b010_100_100_100;
    localparam logic [11:0] L_EG     = 12'b100_100_001_100;
    localparam logic [11:0] L_EY     = 12'b100_100_010_100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] veh_req = 4'd0;
    logic       ped_btn = 1'b0;
    logic [2:0] north, south, east, west;
    logic       walk;
    logic [1:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_phase_arbiter #(
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T),
        .WALK_T    (WALK_T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .veh_req (veh_req),
        .ped_btn (ped_btn),
        .north   (north),
        .south   (south),
        .east    (east),
        .west    (west),
        .walk    (walk),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 all-red, 1 green, 2 yellow, 3 walk.
    // m_cnt is the 1-based number of the current cycle within the mode.
    int m_mode, m_cnt, m_phase;
    bit m_pend;

    task automatic model_step(input logic r, input logic [3:0] v, input logic p);
        bit np;
        bit found;
        bit compete;
        int idx;
        if (r) begin
            m_mode = 0; m_cnt = 1; m_phase = 3; m_pend = 0;
            return;
        end
        np = m_pend || (p && m_mode != 3);
        case (m_mode)
            0: begin
                if (m_cnt >= ALLRED_T) begin
                    if (m_pend) begin
                        m_mode = 3; m_cnt = 1; np = p;
                    end else if (v != 4'd0) begin
                        found = 0;
                        for (int k = 1; k <= 4; k++) begin
                            idx = (m_phase + k) % 4;
                            if (!found && v[idx]) begin
                                found = 1; m_phase = idx;
                            end
                        end
                        m_mode = 1; m_cnt = 1;
                    end
                end else begin
                    m_cnt++;
                end
            end
            1: begin
                compete = m_pend;
                for (int k = 0; k < 4; k++)
                    if (k != m_phase && v[k]) compete = 1;
                if (compete && ((m_cnt >= GREEN_MIN && !v[m_phase]) || m_cnt >= GREEN_MAX)) begin
                    m_mode = 2; m_cnt = 1;
                end else begin
                    m_cnt++;
                end
            end
            2: begin
                if (m_cnt >= YELLOW_T) begin m_mode = 0; m_cnt = 1; end
                else m_cnt++;
            end
            default: begin
                if (m_cnt >= WALK_T) begin m_mode = 0; m_cnt = 1; end
                else m_cnt++;
            end
        endcase
        m_pend = np;
    endtask

    function automatic logic [11:0] model_lights();
        logic [11:0] l;
        l = L_ALLRED;
        if (m_mode == 1) l[11 - 3*m_phase -: 3] = 3'b001;
        else if (m_mode == 2) l[11 - 3*m_phase -: 3] = 3'b010;
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    // One clock: drive inputs, wait past the edge, advance the model and
    // check the model outputs plus the per-cycle safety invariants.
    task automatic cyc(input logic r, input logic [3:0] v, input logic p);
        int nr;
        logic all_red;
        rst = r; veh_req = v; ped_btn = p;
        @(posedge clk);
        #1;
        model_step(r, v, p);
        check("model_lights", 32'({north, south, east, west}), 32'(model_lights()));
        check("model_walk", 32'(walk), 32'(m_mode == 3));
        check("model_phase", 32'(phase), 32'(m_phase));
        check("onehot_lights", 32'($onehot(north) && $onehot(south) &&
                                   $onehot(east) && $onehot(west)), 32'd1);
        nr = int'(north != 3'b100) + int'(south != 3'b100) +
             int'(east != 3'b100) + int'(west != 3'b100);
        check("one_nonred", 32'(nr <= 1), 32'd1);
        all_red = (nr == 0);
        check("walk_allred", 32'(!walk || all_red), 32'd1);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  veh;
        logic        ped;
        int          n;
        logic [11:0] lights;
        logic        wk;
        logic [1:0]  ph;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic p,
                                input int n, input logic [11:0] l, input logic w,
                                input logic [1:0] ph);
        vec_t t;
        t.rst = r; t.veh = v; t.ped = p; t.n = n; t.lights = l; t.wk = w; t.ph = ph;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rv;
        logic       rp, rr;

        // Idle after reset: all red, phase 3, no walk.
        vecs.push_back(mk(1, 4'h0, 0, 2,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h0, 0, 20, L_ALLRED, 0, 2'd3));
        // North only: green after 2 all-red cycles, rests past saturation,
        // then a competing East request forces an immediate max-out.
        vecs.push_back(mk(1, 4'h1, 0, 1,   L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h1, 0, 1,   L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h1, 0, 300, L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h5, 0, 4,   L_NY,     0, 2'd0));
        vecs.push_back(mk(0, 4'h5, 0, 2,   L_ALLRED, 0, 2'd0));
        vecs.push_back(mk(0, 4'h5, 0, 2,   L_EG,     0, 2'd2));
        // North and East held: alternating max-out cycles.
        vecs.push_back(mk(1, 4'h5, 0, 1,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h5, 0, 1,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h5, 0, 32, L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h5, 0, 4,  L_NY,     0, 2'd0));
        vecs.push_back(mk(0, 4'h5, 0, 2,  L_ALLRED, 0, 2'd0));
        vecs.push_back(mk(0, 4'h5, 0, 32, L_EG,     0, 2'd2));
        vecs.push_back(mk(0, 4'h5, 0, 4,  L_EY,     0, 2'd2));
        vecs.push_back(mk(0, 4'h5, 0, 2,  L_ALLRED, 0, 2'd2));
        vecs.push_back(mk(0, 4'h5, 0, 5,  L_NG,     0, 2'd0));
        // Pedestrian press during North green.
        vecs.push_back(mk(1, 4'h1, 0, 1,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h1, 0, 1,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h1, 0, 5,  L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 1, 1,  L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 26, L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 4,  L_NY,     0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 2,  L_ALLRED, 0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 10, L_ALLRED, 1, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 2,  L_ALLRED, 0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 5,  L_NG,     0, 2'd0));
        // Gap-out: North drops in green cycle 3, East waiting -> 8 green cycles.
        vecs.push_back(mk(1, 4'h1, 0, 1, L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h1, 0, 1, L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h1, 0, 3, L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h4, 0, 5, L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h4, 0, 4, L_NY,     0, 2'd0));
        vecs.push_back(mk(0, 4'h4, 0, 2, L_ALLRED, 0, 2'd0));
        vecs.push_back(mk(0, 4'h4, 0, 3, L_EG,     0, 2'd2));
        // Reset in yellow discards a latched press.
        vecs.push_back(mk(1, 4'h5, 0, 1,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h5, 0, 1,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h5, 0, 10, L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h5, 1, 1,  L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h5, 0, 21, L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h5, 0, 2,  L_NY,     0, 2'd0));
        vecs.push_back(mk(1, 4'h5, 0, 1,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h0, 0, 15, L_ALLRED, 0, 2'd3));
        // Press on the all-red expiry cycle is only latched; a press during
        // walk is ignored, so North then rests beyond GREEN_MAX.
        vecs.push_back(mk(1, 4'h1, 0, 1,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h1, 0, 1,  L_ALLRED, 0, 2'd3));
        vecs.push_back(mk(0, 4'h1, 1, 1,  L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 31, L_NG,     0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 4,  L_NY,     0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 2,  L_ALLRED, 0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 4,  L_ALLRED, 1, 2'd0));
        vecs.push_back(mk(0, 4'h1, 1, 1,  L_ALLRED, 1, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 5,  L_ALLRED, 1, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 2,  L_ALLRED, 0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 40, L_NG,     0, 2'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                cyc(vecs[i].rst, vecs[i].veh, vecs[i].ped);
                check($sformatf("tbl%0d.%0d_lights", i, k),
                      32'({north, south, east, west}), 32'(vecs[i].lights));
                check($sformatf("tbl%0d.%0d_walk", i, k), 32'(walk), 32'(vecs[i].wk));
                check($sformatf("tbl%0d.%0d_phase", i, k), 32'(phase), 32'(vecs[i].ph));
            end
        end

        // Randomized traffic against the model, including occasional resets.
        cyc(1, 4'h0, 0);
        rv = 4'h0;
        for (int t = 0; t < 2500; t++) begin
            if ($urandom_range(0, 15) == 0) rv = 4'($urandom_range(0, 15));
            rp = ($urandom_range(0, 39) == 0);
            rr = ($urandom_range(0, 399) == 0);
            cyc(rr, rv, rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
